// File: rtl/fmc_i2c_pkg.sv
// Shared types and slave addresses for the FMC I2C command path.
package fmc_i2c_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GRANT,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } state_t;

    localparam logic [6:0] CPLD_ADDR    = 7'h3E;
    localparam logic [6:0] SI5338B_ADDR = 7'h70;
    localparam logic [6:0] QSFP_ADDR    = 7'h50;

    typedef struct packed {
        logic [6:0] dev_addr;
        logic [7:0] reg_addr;
        logic [7:0] wdata;
        logic       rnw;
    } i2c_cmd_t;

endpackage

// File: rtl/fmc_rr_arbiter.sv
// Round-robin pick: first asserted request at or after rr_ptr, wrapping to 0.
module fmc_rr_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic               any
);
    localparam logic [PTR_W:0] N_L = (PTR_W + 1)'(NUM_REQ);

    logic [PTR_W:0] idx;

    // Scan from the farthest offset down so the nearest hit overwrites the rest.
    always_comb begin
        grant = '0;
        idx   = '0;
        for (int off = NUM_REQ - 1; off >= 0; off--) begin
            idx = {1'b0, rr_ptr} + (PTR_W + 1)'(off);
            if (idx >= N_L) idx = idx - N_L;
            if (req[idx[PTR_W-1:0]]) begin
                grant = '0;
                grant[idx[PTR_W-1:0]] = 1'b1;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/fmc_i2c_cmd_arbiter.sv
// Arbitrates several requesters onto one byte-level I2C master, with a
// per-command timeout that aborts the master and reports back to the requester.
module fmc_i2c_cmd_arbiter
    import fmc_i2c_pkg::*;
#(
    parameter int NUM_REQ     = 3,
    parameter int TIMEOUT_CYC = 200000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [7*NUM_REQ-1:0] req_dev_addr,
    input  logic [8*NUM_REQ-1:0] req_reg_addr,
    input  logic [8*NUM_REQ-1:0] req_wdata,
    input  logic [NUM_REQ-1:0]   req_rnw,
    output logic [NUM_REQ-1:0]   rsp_valid,
    output logic [7:0]           rsp_rdata,
    output logic                 rsp_nack,
    output logic                 rsp_timeout,
    output logic                 m_cmd_valid,
    input  logic                 m_cmd_ready,
    output logic [6:0]           m_dev_addr,
    output logic [7:0]           m_reg_addr,
    output logic [7:0]           m_wdata,
    output logic                 m_rnw,
    input  logic                 m_done,
    input  logic [7:0]           m_rdata,
    input  logic                 m_nack,
    output logic                 m_abort,
    output logic                 busy
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_REQ - 1);

    state_t             state, state_nxt;
    logic [PTR_W-1:0]   rr_ptr;
    logic [NUM_REQ-1:0] arb_grant, grant_q;
    logic               arb_any;
    logic [PTR_W-1:0]   grant_idx;
    i2c_cmd_t           sel_cmd, cmd_q;
    logic [CNT_W-1:0]   tmo_cnt;
    logic [7:0]         rdata_q;
    logic               nack_q, tmo_q;
    logic               tmo_hit, done_hit;

    fmc_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_arbiter (
        .req    (req_valid),
        .rr_ptr (rr_ptr),
        .grant  (arb_grant),
        .any    (arb_any)
    );

    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (grant_q[i]) grant_idx = PTR_W'(i);
    end

    always_comb begin
        sel_cmd = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q[i]) begin
                sel_cmd.dev_addr = req_dev_addr[7*i +: 7];
                sel_cmd.reg_addr = req_reg_addr[8*i +: 8];
                sel_cmd.wdata    = req_wdata[8*i +: 8];
                sel_cmd.rnw      = req_rnw[i];
            end
        end
    end

    // Completion is only honoured in WAIT; it beats a coincident timeout.
    assign tmo_hit  = ((state == ST_ISSUE) || (state == ST_WAIT)) && (tmo_cnt == TMO_LAST);
    assign done_hit = (state == ST_WAIT) && m_done;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (arb_any) state_nxt = ST_GRANT;
            ST_GRANT: state_nxt = ST_ISSUE;
            ST_ISSUE: begin
                if (tmo_hit)          state_nxt = ST_RESP;
                else if (m_cmd_ready) state_nxt = ST_WAIT;
            end
            ST_WAIT:  if (done_hit || tmo_hit) state_nxt = ST_RESP;
            ST_RESP:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr  <= '0;
            grant_q <= '0;
            cmd_q   <= '0;
            tmo_cnt <= '0;
            rdata_q <= '0;
            nack_q  <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            if ((state == ST_IDLE) && arb_any) grant_q <= arb_grant;

            if (state == ST_GRANT) begin
                cmd_q   <= sel_cmd;
                tmo_cnt <= '0;
            end else if ((state == ST_ISSUE) || (state == ST_WAIT)) begin
                tmo_cnt <= tmo_cnt + CNT_W'(1);
            end

            if (done_hit) begin
                rdata_q <= cmd_q.rnw ? m_rdata : 8'h00;
                nack_q  <= m_nack;
                tmo_q   <= 1'b0;
            end else if (tmo_hit) begin
                rdata_q <= 8'h00;
                nack_q  <= 1'b0;
                tmo_q   <= 1'b1;
            end

            if (state == ST_RESP)
                rr_ptr <= (grant_idx == PTR_LAST) ? '0 : grant_idx + PTR_W'(1);
        end
    end

    assign req_ready   = (state == ST_GRANT) ? grant_q : '0;
    assign m_cmd_valid = (state == ST_ISSUE);
    assign m_dev_addr  = cmd_q.dev_addr;
    assign m_reg_addr  = cmd_q.reg_addr;
    assign m_wdata     = cmd_q.wdata;
    assign m_rnw       = cmd_q.rnw;
    assign m_abort     = tmo_hit && !done_hit;
    assign rsp_valid   = (state == ST_RESP) ? grant_q : '0;
    assign rsp_rdata   = (state == ST_RESP) ? rdata_q : 8'h00;
    assign rsp_nack    = (state == ST_RESP) && nack_q;
    assign rsp_timeout = (state == ST_RESP) && tmo_q;
    assign busy        = (state != ST_IDLE);

endmodule

// File: tb/tb_fmc_i2c_cmd_arbiter.sv
// Directed bench for fmc_i2c_cmd_arbiter: transaction-timeline model plus literal checks.
module tb_fmc_i2c_cmd_arbiter;
    import fmc_i2c_pkg::*;

    localparam int NR  = 3;
    localparam int TMO = 16;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [NR-1:0]   req_valid = '0, req_ready, req_rnw = '0, rsp_valid;
    logic [7*NR-1:0] req_dev_addr = '0;
    logic [8*NR-1:0] req_reg_addr = '0, req_wdata = '0;
    logic [7:0]      rsp_rdata, m_reg_addr, m_wdata, m_rdata;
    logic            rsp_nack, rsp_timeout, m_cmd_valid, m_cmd_ready, m_rnw;
    logic [6:0]      m_dev_addr;
    logic            m_done, m_nack, m_abort, busy;

    fmc_i2c_cmd_arbiter #(.NUM_REQ(NR), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_dev_addr(req_dev_addr), .req_reg_addr(req_reg_addr), .req_wdata(req_wdata),
        .req_rnw(req_rnw), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_nack(rsp_nack),
        .rsp_timeout(rsp_timeout), .m_cmd_valid(m_cmd_valid), .m_cmd_ready(m_cmd_ready),
        .m_dev_addr(m_dev_addr), .m_reg_addr(m_reg_addr), .m_wdata(m_wdata), .m_rnw(m_rnw),
        .m_done(m_done), .m_rdata(m_rdata), .m_nack(m_nack), .m_abort(m_abort), .busy(busy)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0, cyc = 0;

    // Master behaviour knobs (lat==0: never completes)
    int         rdy_dly = 0, lat = 1;
    logic [7:0] mst_rdata = 8'h00;
    logic       mst_nack = 1'b0;
    bit         stray = 1'b0;

    // Model: a transaction is k cycles old; k==1 is the accept cycle.
    bit         md_act = 0, md_resp = 0, md_acc = 0;
    int         md_k = 0, md_g = 0, md_ptr = 0;
    logic [6:0] md_dev = '0;
    logic [7:0] md_reg = '0, md_wd = '0, md_rdata = '0;
    logic       md_rnw = 0, md_nack = 0, md_tmo = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            if (bad <= 40) $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, got, exp);
        end
    endtask

    function automatic int pick(input logic [NR-1:0] v, input int p);
        for (int o = 0; o < NR; o++)
            if (((v >> ((p + o) % NR)) & NR'(1)) != '0) return (p + o) % NR;
        return 0;
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin : model
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            md_act = 0; md_resp = 0; md_ptr = 0;
        end else if (!md_act) begin
            if (req_valid != '0) begin
                md_g = pick(req_valid, md_ptr);
                md_act = 1; md_k = 1; md_acc = 0; md_resp = 0;
            end
        end else if (md_resp) begin
            md_act = 0; md_resp = 0;
            md_ptr = (md_g + 1) % NR;
        end else begin
            if (md_k == 1) begin
                md_dev = 7'(req_dev_addr >> (7 * md_g));
                md_reg = 8'(req_reg_addr >> (8 * md_g));
                md_wd  = 8'(req_wdata >> (8 * md_g));
                md_rnw = 1'((req_rnw >> md_g) & NR'(1));
            end else if (md_acc && m_done) begin
                md_resp = 1; md_rdata = md_rnw ? m_rdata : 8'h00; md_nack = m_nack; md_tmo = 0;
            end else if (md_k == TMO + 1) begin
                md_resp = 1; md_rdata = 8'h00; md_nack = 0; md_tmo = 1;
            end else if (!md_acc && m_cmd_ready) begin
                md_acc = 1;
            end
            md_k++;
        end
    end

    initial forever begin : compare
        logic [NR-1:0] e_rr, e_rv;
        logic          e_cv, e_ab;
        @(negedge clk);
        e_rr = (md_act && !md_resp && md_k == 1) ? (NR'(1) << md_g) : '0;
        e_rv = (md_act && md_resp) ? (NR'(1) << md_g) : '0;
        e_cv = md_act && !md_resp && md_k >= 2 && !md_acc;
        e_ab = md_act && !md_resp && md_k == TMO + 1 && !(md_acc && m_done);
        chk("busy", 32'(busy), 32'(md_act));
        chk("req_ready", 32'(req_ready), 32'(e_rr));
        chk("m_cmd_valid", 32'(m_cmd_valid), 32'(e_cv));
        chk("m_abort", 32'(m_abort), 32'(e_ab));
        chk("rsp_valid", 32'(rsp_valid), 32'(e_rv));
        if (e_cv) begin
            chk("m_dev_addr", 32'(m_dev_addr), 32'(md_dev));
            chk("m_reg_addr", 32'(m_reg_addr), 32'(md_reg));
            chk("m_wdata", 32'(m_wdata), 32'(md_wd));
            chk("m_rnw", 32'(m_rnw), 32'(md_rnw));
        end
        if (md_act && md_resp) begin
            chk("rsp_rdata", 32'(rsp_rdata), 32'(md_rdata));
            chk("rsp_nack", 32'(rsp_nack), 32'(md_nack));
            chk("rsp_timeout", 32'(rsp_timeout), 32'(md_tmo));
        end
    end

    initial begin : master
        int vcnt, dcnt;
        bit acc;
        m_cmd_ready = 0; m_done = 0; m_rdata = 0; m_nack = 0; vcnt = 0; dcnt = 0;
        forever begin
            @(negedge clk);
            acc = 0;
            if (!rst_n) begin vcnt = 0; dcnt = 0; end
            else if (m_cmd_valid && m_cmd_ready) begin vcnt = 0; acc = 1; end
            else if (m_cmd_valid) vcnt++;
            else vcnt = 0;
            if (acc && lat > 0) dcnt = lat;
            @(posedge clk); #1;
            m_cmd_ready = rst_n && (vcnt > rdy_dly);
            m_done  = (dcnt == 1) || stray;
            m_nack  = (dcnt == 1) ? mst_nack : 1'b0;
            m_rdata = mst_rdata;
            if (dcnt > 0) dcnt--;
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic set_req(input int i, input logic [6:0] d, input logic [7:0] r,
                           input logic [7:0] w, input logic rnw);
        req_dev_addr = (req_dev_addr & ~((7*NR)'(7'h7F) << (7 * i))) | ((7*NR)'(d) << (7 * i));
        req_reg_addr = (req_reg_addr & ~((8*NR)'(8'hFF) << (8 * i))) | ((8*NR)'(r) << (8 * i));
        req_wdata    = (req_wdata & ~((8*NR)'(8'hFF) << (8 * i))) | ((8*NR)'(w) << (8 * i));
        req_rnw      = (req_rnw & ~(NR'(1) << i)) | (NR'(rnw) << i);
    endtask

    task automatic wait_ready(output logic [NR-1:0] got, output int at);
        got = '0; at = -1;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (req_ready != '0) begin got = req_ready; at = cyc; return; end
        end
        chk("req_ready_wait_expired", 32'(0), 32'(1));
    endtask

    task automatic wait_rsp(output int at);
        at = -1;
        for (int n = 0; n < 80; n++) begin
            @(negedge clk);
            if (rsp_valid != '0) begin at = cyc; return; end
        end
        chk("rsp_valid_wait_expired", 32'(0), 32'(1));
    endtask

    task automatic wait_abort(output int at);
        at = -1;
        for (int n = 0; n < 80; n++) begin
            @(negedge clk);
            if (m_abort) begin at = cyc; return; end
        end
        chk("m_abort_wait_expired", 32'(0), 32'(1));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req_ready"}, 32'(req_ready), 32'(0));
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'(0));
        chk({tag, "_rsp_misc"}, 32'({rsp_rdata, rsp_nack, rsp_timeout}), 32'(0));
        chk({tag, "_m_cmd"}, 32'({m_cmd_valid, m_dev_addr, m_reg_addr, m_wdata, m_rnw}), 32'(0));
        chk({tag, "_abort_busy"}, 32'({m_abort, busy}), 32'(0));
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : stim
        logic [NR-1:0] got;
        logic [NR-1:0] ord [4];
        int c0, tg, ta, tr, prev;
        ord = '{3'b001, 3'b010, 3'b100, 3'b001};

        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        tick(); rst_n = 1'b1;
        repeat (2) tick();

        // single write from CPLD requester; fields change after acceptance
        rdy_dly = 0; lat = 1; mst_rdata = 8'hC3;
        set_req(0, CPLD_ADDR, 8'h00, 8'h01, 1'b0);
        tick(); c0 = cyc; req_valid = 3'b001;
        wait_ready(got, tg);
        chk("wr_ready", 32'(got), 32'(3'b001));
        chk("wr_ready_lat", 32'(tg - c0), 32'(1));
        tick(); req_valid = '0; set_req(0, 7'h11, 8'h22, 8'h33, 1'b1);
        @(negedge clk);
        chk("wr_cmd", 32'({m_cmd_valid, m_dev_addr, m_reg_addr, m_wdata, m_rnw}),
            32'({1'b1, 7'h3E, 8'h00, 8'h01, 1'b0}));
        wait_rsp(tr);
        chk("wr_rsp", 32'({rsp_valid, rsp_rdata, rsp_nack, rsp_timeout}), 32'({3'b001, 8'h00, 2'b00}));
        repeat (2) tick();

        // read from SI5338 requester
        mst_rdata = 8'hA5;
        set_req(1, SI5338B_ADDR, 8'hE6, 8'h00, 1'b1);
        tick(); req_valid = 3'b010;
        wait_ready(got, tg);
        chk("rd_ready", 32'(got), 32'(3'b010));
        tick(); req_valid = '0;
        wait_rsp(tr);
        chk("rd_rsp", 32'({rsp_valid, rsp_rdata, rsp_nack}), 32'({3'b010, 8'hA5, 1'b0}));
        repeat (2) tick();

        // NACK on QSFP requester
        mst_nack = 1'b1;
        set_req(2, QSFP_ADDR, 8'h7F, 8'h3C, 1'b0);
        tick(); req_valid = 3'b100;
        wait_ready(got, tg);
        tick(); req_valid = '0;
        wait_rsp(tr);
        chk("nack_rsp", 32'({rsp_valid, rsp_nack, rsp_timeout}), 32'({3'b100, 2'b10}));
        tick(); mst_nack = 1'b0;
        repeat (2) tick();

        // fairness with all three held
        set_req(0, CPLD_ADDR, 8'h01, 8'hF0, 1'b0);
        set_req(1, SI5338B_ADDR, 8'h02, 8'h0F, 1'b1);
        tick(); req_valid = 3'b111;
        prev = 0;
        for (int n = 0; n < 4; n++) begin
            wait_ready(got, tg);
            chk($sformatf("rr_order%0d", n), 32'(got), 32'(ord[n]));
            if (n > 0) chk("rr_gap_ge5", 32'(tg - prev >= 5), 32'(1));
            prev = tg;
        end
        tick(); req_valid = '0;
        wait_rsp(tr);
        repeat (2) tick();

        // timeout in WAIT: master accepts but never completes
        lat = 0;
        tick(); req_valid = 3'b010;
        wait_ready(got, tg);
        chk("tmo_ready", 32'(got), 32'(3'b010));
        tick(); req_valid = '0;
        wait_abort(ta);
        chk("tmo_abort_cyc", 32'(ta - tg), 32'(16));
        @(negedge clk);
        chk("tmo_rsp", 32'({rsp_valid, rsp_rdata, rsp_nack, rsp_timeout, m_abort}),
            32'({3'b010, 8'h00, 1'b0, 1'b1, 1'b0}));
        repeat (2) tick();

        // timeout in ISSUE: master never ready
        rdy_dly = 1000;
        tick(); req_valid = 3'b100;
        wait_ready(got, tg);
        tick(); req_valid = '0;
        wait_abort(ta);
        chk("iss_abort_cyc", 32'(ta - tg), 32'(16));
        @(negedge clk);
        chk("iss_rsp", 32'({rsp_valid, rsp_timeout, m_cmd_valid}), 32'({3'b100, 1'b1, 1'b0}));
        repeat (2) tick();

        // done lands on the timeout cycle: normal response
        rdy_dly = 0; lat = 14; mst_rdata = 8'h5A;
        set_req(0, CPLD_ADDR, 8'h10, 8'h00, 1'b1);
        tick(); req_valid = 3'b001;
        wait_ready(got, tg);
        chk("race_ready", 32'(got), 32'(3'b001));
        tick(); req_valid = '0;
        wait_rsp(tr);
        chk("race_rsp_cyc", 32'(tr - tg), 32'(17));
        chk("race_rsp", 32'({rsp_valid, rsp_rdata, rsp_timeout}), 32'({3'b001, 8'h5A, 1'b0}));
        repeat (2) tick();

        // stray done while idle
        @(negedge clk); stray = 1'b1;
        repeat (2) @(negedge clk);
        stray = 1'b0;
        chk("stray_busy", 32'({busy, rsp_valid}), 32'(0));
        repeat (2) tick();

        // reset while waiting on the master
        lat = 0;
        tick(); req_valid = 3'b010;
        wait_ready(got, tg);
        tick(); req_valid = '0;
        repeat (4) @(negedge clk);
        chk("pre_rst_busy", 32'(busy), 32'(1));
        @(posedge clk); #1; rst_n = 1'b0;
        #1;
        chk_all_zero("async_rst");
        repeat (2) tick();
        rst_n = 1'b1;
        lat = 1;
        tick(); req_valid = 3'b011;
        wait_ready(got, tg);
        chk("post_rst_grant", 32'(got), 32'(3'b001));
        tick(); req_valid = '0;
        wait_rsp(tr);
        chk("post_rst_rsp", 32'(rsp_valid), 32'(3'b001));
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fmc_i2c_cmd_arbiter.md
FMC_I2C_CMD_ARBITER -- requirements
Module: fmc_i2c_cmd_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 3, number of requesters (CPLD LED ctrl, SI5338 config, QSFP mgmt).
REQ-002 SHALL have parameter TIMEOUT_CYC, default 200000, max cycles from command issue to M_DONE.
REQ-003 SHALL have CLK  in  1  single clock for all logic.
REQ-004 SHALL have RST_N  in  1  reset; asynchronous, active-low.
REQ-005 SHALL have REQ_VALID  in  NUM_REQ  per-requester command valid.
REQ-006 SHALL have REQ_READY  out  NUM_REQ  one-hot single-cycle accept strobe.
REQ-007 SHALL have REQ_DEV_ADDR  in  7*NUM_REQ  packed 7-bit I2C slave addresses, requester i at [7i+6:7i].
REQ-008 SHALL have REQ_REG_ADDR / REQ_WDATA  in  8*NUM_REQ each  packed register address / write data.
REQ-009 SHALL have REQ_RNW  in  NUM_REQ  1 = read, 0 = write.
REQ-010 SHALL have RSP_VALID  out  NUM_REQ  one-hot single-cycle completion strobe; RSP_RDATA out 8, RSP_NACK out 1, RSP_TIMEOUT out 1, shared, valid only with RSP_VALID.
REQ-011 SHALL have M_CMD_VALID out 1, M_CMD_READY in 1, M_DEV_ADDR out 7, M_REG_ADDR out 8, M_WDATA out 8, M_RNW out 1: command port to byte-level I2C master.
REQ-012 SHALL have M_DONE in 1, M_RDATA in 8, M_NACK in 1 (completion from master), M_ABORT out 1 (single-cycle abort strobe), BUSY out 1 (state != IDLE).

Function
REQ-013 SHALL implement FSM states IDLE, GRANT, ISSUE, WAIT, RESP.
REQ-014 IDLE: any REQ_VALID -> GRANT; grant = first asserted index at or after rr_ptr, wrapping NUM_REQ-1 -> 0.
REQ-015 GRANT: SHALL pulse REQ_READY[grant] one cycle, latch that requester's addr/reg/wdata/rnw, -> ISSUE.
REQ-016 ISSUE: M_CMD_VALID=1 with latched fields held stable until M_CMD_READY sampled high, then -> WAIT; first M_CMD_VALID 2 cycles after REQ_VALID seen in IDLE.
REQ-017 WAIT: on M_DONE SHALL latch M_RDATA and M_NACK, -> RESP; M_DONE outside WAIT ignored.
REQ-018 Timeout counter SHALL clear on GRANT, count in ISSUE and WAIT; reaching TIMEOUT_CYC-1 without completion -> pulse M_ABORT, drop M_CMD_VALID, -> RESP with RSP_TIMEOUT=1, RSP_NACK=0, RSP_RDATA=0.
REQ-019 M_DONE and timeout in same cycle: M_DONE wins, no abort.
REQ-020 RESP: RSP_VALID[grant] one cycle, rr_ptr <= grant+1 mod NUM_REQ, -> IDLE; RSP_RDATA = 0 for writes.
REQ-021 Requester dropping REQ_VALID after acceptance SHALL NOT affect the in-flight transaction; changes on non-granted inputs ignored.
REQ-022 Back-to-back: minimum 5 cycles between successive REQ_READY strobes (excluding master latency).

Reset
REQ-023 RST_N low SHALL immediately force state IDLE, rr_ptr 0, counter 0, and all outputs (REQ_READY, RSP_*, M_CMD_VALID, M_DEV_ADDR, M_REG_ADDR, M_WDATA, M_RNW, M_ABORT, BUSY) to 0.
REQ-024 Reset mid-transaction SHALL discard it with no RSP_VALID and no M_ABORT; downstream master resets on same RST_N.

Structure
REQ-025 Shared package fmc_i2c_pkg SHALL hold FSM state enum and slave address constants: CPLD 7'h3E, SI5338B 7'h70, QSFP 7'h50.
REQ-026 Round-robin selection SHALL be sub-module fmc_rr_arbiter (inputs req vector, rr_ptr; output one-hot grant, any).
REQ-027 Datapath registers and FSM in this module; no combinational path from REQ_* to M_*.

Verification
REQ-028 Single write: REQ_VALID[0], dev 7'h3E, reg 8'h00, wdata 8'h01 -> REQ_READY[0] next cycle, M_CMD_VALID cycle after with same fields, M_DONE -> RSP_VALID[0], NACK 0.
REQ-029 Read: req 1 dev 7'h70 reg 8'hE6 rnw 1, M_RDATA 8'hA5 -> RSP_VALID[1], RSP_RDATA 8'hA5.
REQ-030 Fairness: all three REQ_VALID held high -> grant order 0,1,2,0 with rr_ptr wrap.
REQ-031 Timeout: TIMEOUT_CYC=16, never assert M_DONE -> M_ABORT pulse and RSP_TIMEOUT=1 after 16 cycles from GRANT; M_DONE with timeout same cycle -> normal response.
REQ-032 NACK: M_NACK=1 with M_DONE -> RSP_NACK=1 to granted requester only.
REQ-033 Reset in WAIT: RST_N low -> all outputs 0 asynchronously, no RSP_VALID; next request granted from index 0.
